// File: rtl/id_fetch_buffer.sv
// id_fetch_buffer
//
// Two-entry skid buffer sitting between instruction fetch and decode in the
// 32-bit MIPS datapath. Fetched words enter with their PC. The oldest entry
// (head) is presented to decode split into MIPS fields, together with a
// format class, a zero-extension hint for logical immediates, and PC+4.
//
// Ports:
//   clk, rst_n      single clock, synchronous active-low reset
//   flush           drop every buffered entry (branch/jump redirect)
//   in_valid/in_ready, in_instr, in_pc   fetch side handshake and payload
//   out_valid/out_ready                  decode side handshake
//   opcode, rs, rt, rd, shamt, funct, imm, jtarget   head field decodes
//   pc_plus4        head PC + 4, modulo 2^ADDR_W
//   fmt             00 R-type, 10 J-type, 01 I-type
//   zero_ext        head is andi/ori/xori
//   is_nop          head word is all zeros
module id_fetch_buffer #(
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] RESET_PC_PLUS4 = 32'h0000_0004
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm,
    output logic [25:0]       jtarget,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [1:0]        fmt,
    output logic              zero_ext,
    output logic              is_nop
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Head PC is reset so that the PC+4 adder already shows RESET_PC_PLUS4.
    localparam logic [ADDR_W-1:0] RESET_HEAD_PC = RESET_PC_PLUS4 - ADDR_W'(4);

    state_t            state_q, state_d;
    logic [31:0]       head_instr_q, head_instr_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

    logic acc;
    logic pop;

    // Both handshake outputs come straight from the state register, so
    // in_ready has no combinational dependence on out_ready.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            // Head contents are left as-is; only occupancy is cleared. Any
            // word offered this cycle is dropped with the rest.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d      = ONE;
                        head_instr_d = in_instr;
                        head_pc_d    = in_pc;
                    end
                end
                ONE: begin
                    if (acc && !pop) begin
                        state_d      = TWO;
                        skid_instr_d = in_instr;
                        skid_pc_d    = in_pc;
                    end else if (acc && pop) begin
                        head_instr_d = in_instr;
                        head_pc_d    = in_pc;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d      = ONE;
                        head_instr_d = skid_instr_q;
                        head_pc_d    = skid_pc_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            head_instr_q <= 32'h0;
            head_pc_q    <= RESET_HEAD_PC;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // Field decodes of the head register.
    assign opcode   = head_instr_q[31:26];
    assign rs       = head_instr_q[25:21];
    assign rt       = head_instr_q[20:16];
    assign rd       = head_instr_q[15:11];
    assign shamt    = head_instr_q[10:6];
    assign funct    = head_instr_q[5:0];
    assign imm      = head_instr_q[15:0];
    assign jtarget  = head_instr_q[25:0];
    assign pc_plus4 = head_pc_q + ADDR_W'(4);
    assign is_nop   = (head_instr_q == 32'h0);

    always_comb begin
        fmt      = 2'b01;
        zero_ext = 1'b0;
        if (opcode == 6'h00) begin
            fmt = 2'b00;
        end else if (opcode == 6'h02 || opcode == 6'h03) begin
            fmt = 2'b10;
        end
        if (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E) begin
            zero_ext = 1'b1;
        end
    end

endmodule

// File: tb/tb_id_fetch_buffer.sv
// tb_id_fetch_buffer
//
// Directed bench for id_fetch_buffer: reset values, field decode, back-pressure
// fill to two entries, back-to-back streaming, flush, PC wrap, and reset while
// full. Inputs change 1 time unit after the rising edge; outputs are sampled
// at the same point, after the DUT has settled.
module tb_id_fetch_buffer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] jtarget;
    logic [31:0] pc_plus4;
    logic [1:0]  fmt;
    logic        zero_ext;
    logic        is_nop;

    int n_cmp = 0;
    int n_bad = 0;

    id_fetch_buffer #(
        .ADDR_W        (32),
        .RESET_PC_PLUS4(32'h0000_0004)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .in_pc    (in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .opcode   (opcode),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .shamt    (shamt),
        .funct    (funct),
        .imm      (imm),
        .jtarget  (jtarget),
        .pc_plus4 (pc_plus4),
        .fmt      (fmt),
        .zero_ext (zero_ext),
        .is_nop   (is_nop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        chk("rst_opcode",    32'(opcode),    32'h0);
        chk("rst_imm",       32'(imm),       32'h0);
        chk("rst_jtarget",   32'(jtarget),   32'h0);
        chk("rst_fmt",       32'(fmt),       32'h0);
        chk("rst_zero_ext",  32'(zero_ext),  32'h0);
        chk("rst_is_nop",    32'(is_nop),    32'h1);
        chk("rst_pc_plus4",  pc_plus4,       32'h4);

        // addi $t0,$zero,-10 at 0x100
        push(32'h2008FFF6, 32'h100);
        chk("addi_valid",    32'(out_valid), 32'h1);
        chk("addi_opcode",   32'(opcode),    32'h08);
        chk("addi_rs",       32'(rs),        32'h0);
        chk("addi_rt",       32'(rt),        32'h8);
        chk("addi_imm",      32'(imm),       32'hFFF6);
        chk("addi_fmt",      32'(fmt),       32'h1);
        chk("addi_zext",     32'(zero_ext),  32'h0);
        chk("addi_pc4",      pc_plus4,       32'h104);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("addi_drained",  32'(out_valid), 32'h0);

        // Back-pressure: ori then add fill the buffer; lw is held off
        push(32'h3403000F, 32'h200);
        chk("bp_ready_one",  32'(in_ready),  32'h1);
        push(32'h012A4020, 32'h204);
        chk("bp_ready_two",  32'(in_ready),  32'h0);
        in_valid = 1'b1;
        in_instr = 32'h8D090008;
        in_pc    = 32'h208;
        step();
        step();
        chk("bp_hold_ready", 32'(in_ready),  32'h0);
        chk("bp_hold_valid", 32'(out_valid), 32'h1);
        chk("bp_ori_opcode", 32'(opcode),    32'h0D);
        chk("bp_ori_zext",   32'(zero_ext),  32'h1);
        chk("bp_ori_imm",    32'(imm),       32'h000F);
        chk("bp_ori_pc4",    pc_plus4,       32'h204);
        out_ready = 1'b1;
        step();
        chk("bp_add_fmt",    32'(fmt),       32'h0);
        chk("bp_add_rs",     32'(rs),        32'h9);
        chk("bp_add_rt",     32'(rt),        32'hA);
        chk("bp_add_rd",     32'(rd),        32'h8);
        chk("bp_add_shamt",  32'(shamt),     32'h0);
        chk("bp_add_funct",  32'(funct),     32'h20);
        chk("bp_add_pc4",    pc_plus4,       32'h208);
        chk("bp_add_ready",  32'(in_ready),  32'h1);
        step();
        in_valid = 1'b0;
        chk("bp_lw_opcode",  32'(opcode),    32'h23);
        chk("bp_lw_pc4",     pc_plus4,       32'h20C);
        chk("bp_lw_imm",     32'(imm),       32'h0008);
        step();
        chk("bp_drained",    32'(out_valid), 32'h0);

        // Streaming: eight words with accept and pop in the same cycle
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_instr = 32'h20000000 | 32'(k);
            in_pc    = 32'h300 + 32'(4 * k);
            step();
            chk("stream_valid", 32'(out_valid), 32'h1);
            chk("stream_ready", 32'(in_ready),  32'h1);
            chk("stream_imm",   32'(imm),       32'(k));
            chk("stream_pc4",   pc_plus4,       32'h304 + 32'(4 * k));
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", 32'(out_valid), 32'h0);
        out_ready = 1'b0;

        // Flush from TWO with a word offered
        push(32'h24010001, 32'h400);
        push(32'h24020002, 32'h404);
        chk("fl_two_ready",  32'(in_ready),  32'h0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h24030003;
        in_pc    = 32'h408;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_two_valid",  32'(out_valid), 32'h0);
        chk("fl_two_ready2", 32'(in_ready),  32'h1);
        chk("fl_stale_imm",  32'(imm),       32'h0001);

        // Flush from ONE: the offered word is dropped although in_ready=1
        push(32'h24040004, 32'h40C);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h24050005;
        in_pc    = 32'h410;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_one_valid",  32'(out_valid), 32'h0);
        chk("fl_one_stale",  32'(imm),       32'h0004);
        push(32'h24060006, 32'h414);
        chk("fl_next_imm",   32'(imm),       32'h0006);
        out_ready = 1'b1;
        step();
        chk("fl_next_only",  32'(out_valid), 32'h0);
        out_ready = 1'b0;

        // jal at the top of the address space, then a nop via accept+pop
        push(32'h0C000040, 32'hFFFFFFFC);
        chk("jal_fmt",       32'(fmt),       32'h2);
        chk("jal_opcode",    32'(opcode),    32'h03);
        chk("jal_jtarget",   32'(jtarget),   32'h0000040);
        chk("jal_pc4",       pc_plus4,       32'h0);
        chk("jal_is_nop",    32'(is_nop),    32'h0);
        out_ready = 1'b1;
        push(32'h00000000, 32'h500);
        chk("nop_is_nop",    32'(is_nop),    32'h1);
        chk("nop_fmt",       32'(fmt),       32'h0);
        chk("nop_pc4",       pc_plus4,       32'h504);
        step();
        chk("nop_drained",   32'(out_valid), 32'h0);
        out_ready = 1'b0;

        // Reset while holding two entries
        push(32'h3C01ABCD, 32'h600);
        push(32'h3C02BEEF, 32'h604);
        chk("rst2_ready_pre", 32'(in_ready), 32'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst2_valid",    32'(out_valid), 32'h0);
        chk("rst2_ready",    32'(in_ready),  32'h1);
        chk("rst2_opcode",   32'(opcode),    32'h0);
        chk("rst2_imm",      32'(imm),       32'h0);
        chk("rst2_is_nop",   32'(is_nop),    32'h1);
        chk("rst2_pc4",      pc_plus4,       32'h4);
        push(32'h3C03CAFE, 32'h700);
        chk("post_valid",    32'(out_valid), 32'h1);
        chk("post_opcode",   32'(opcode),    32'h0F);
        chk("post_imm",      32'(imm),       32'hCAFE);
        chk("post_pc4",      pc_plus4,       32'h704);
        out_ready = 1'b1;
        step();
        chk("post_drained",  32'(out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_fetch_buffer.md
Name: id_fetch_buffer

Overview:
- Two-entry skid buffer between instruction fetch and decode in the 32-bit MIPS datapath.
- Accepts fetched instruction words with their PC.
- Presents the head entry split into MIPS fields, including the raw 16-bit immediate that feeds the sign-extension unit.
- Classifies the instruction format, flags immediates that need zero-extension, and supports pipeline flush and back-pressure.

Parameters:
- ADDR_W, 32, width of PC and PC+4 paths
- RESET_PC_PLUS4, 32'h0000_0004, value of pc_plus4 output after reset

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- flush  input  1  discard all buffered entries (branch/jump redirect)
- in_valid  input  1  fetch presents a word
- in_ready  output  1  buffer can accept a word this cycle
- in_instr  input  32  fetched instruction word
- in_pc  input  ADDR_W  address of in_instr
- out_valid  output  1  head entry valid
- out_ready  input  1  decode consumes the head entry this cycle
- opcode  output  6  head instr[31:26]
- rs  output  5  head instr[25:21]
- rt  output  5  head instr[20:16]
- rd  output  5  head instr[15:11]
- shamt  output  5  head instr[10:6]
- funct  output  6  head instr[5:0]
- imm  output  16  head instr[15:0], to sign_extend
- jtarget  output  26  head instr[25:0]
- pc_plus4  output  ADDR_W  head PC + 4, wraps modulo 2^ADDR_W
- fmt  output  2  00 R-type (opcode 0), 10 J-type (opcode 2 or 3), 01 all other opcodes (I-type)
- zero_ext  output  1  1 when opcode is 0x0C, 0x0D or 0x0E (andi/ori/xori)
- is_nop  output  1  head instr == 32'h0

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst_n` is synchronous and active-low. All state updates on the rising edge of `clk`.
- State: EMPTY, ONE, TWO, held in registered count plus head and skid entry registers {instr, pc}.
- Reset (rst_n=0 at edge):
  - state EMPTY, out_valid 0, in_ready 1 from the first cycle after reset.
  - All field outputs 0, fmt 00, zero_ext 0, is_nop 1, pc_plus4 = RESET_PC_PLUS4.
  - Reset overrides flush and all handshakes.
- Accept: acc = in_valid & in_ready. Consume: pop = out_valid & out_ready.
- in_ready = (state != TWO); registered, no combinational path from out_ready.
- Transitions (flush=0):
  - EMPTY: acc -> ONE, word written to head.
  - ONE: acc & !pop -> TWO, word written to skid. acc & pop -> ONE, word written to head. !acc & pop -> EMPTY. Otherwise hold.
  - TWO: pop -> ONE, skid moves to head. Otherwise hold.
- Latency: a word accepted at edge N is on the outputs with out_valid=1 after edge N when the buffer was empty.
- Ordering: strict FIFO; no word dropped or duplicated without flush.
- Flush:
  - flush=1 at edge -> state EMPTY and out_valid 0 next cycle.
  - A word offered in the same cycle is discarded, even if in_ready=1.
  - A pop in the same cycle still counts as consumed by downstream.
  - Head registers are not cleared; field outputs hold stale values.
- Field outputs are combinational decodes of the head register only; meaningful only while out_valid=1. They hold their last value when EMPTY.
- pc_plus4 = head pc + 4 computed on ADDR_W bits; 0xFFFF_FFFC gives 0x0000_0000.
- Outputs are stable while out_valid=1 and out_ready=0 (no head change under back-pressure).

Test Plan:
- Reset, then accept 0x2008FFF6 (addi $t0,$zero,-10) at pc 0x100 -> next cycle out_valid=1, opcode 0x08, rs 0, rt 8, imm 0xFFF6, fmt 01, zero_ext 0, pc_plus4 0x104.
- out_ready=0; push 0x3403000F then 0x012A4020 -> second push sets in_ready=0. A third word held on in_valid is not accepted. Fields stay at the ori word (zero_ext 1, imm 0x000F). Raise out_ready -> add word appears with fmt 00, rd 8, funct 0x20. Then the third word appears. All in order.
- Simultaneous acc & pop in state ONE for 8 back-to-back words with out_ready=1 -> one word out per cycle, in_ready never drops, order preserved.
- Fill to TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1. Flushed and same-cycle words never appear.
- Push 0x0C000040 (jal) at pc 0xFFFFFFFC -> fmt 10, jtarget 0x0000040, pc_plus4 0x00000000. Push 0x00000000 -> is_nop 1, fmt 00.
- Assert rst_n=0 for one edge while in TWO with flush=0 -> out_valid 0, in_ready 1, all fields 0. The buffer then accepts new words normally.
